// File: rtl/uart_rx_sipo.sv
// UART receive deserializer: oversampled start detect, 7/8 data bits LSB first,
// optional parity, 1/2 stop bits; one-cycle rx_done pulse with held byte and error flags.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 vote around each sample point (+1 cycle latency).
module uart_rx_sipo #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       baud_clk,
  input  logic       arst_n,
  input  logic       rx,
  input  logic       data_length,
  input  logic       stop_bits,
  input  logic [1:0] parity_type,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       rx_active,
  output logic       parity_err,
  output logic       frame_err
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] LAST_PT = CW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_EN
  // The vote needs the sample after the nominal point, so every decision lands one cycle late.
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2);
`else
  localparam logic [CW-1:0] START_PT = CW'(OVERSAMPLE / 2 - 1);
`endif

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP1, S_STOP2} state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic [CW-1:0]          cnt_q;
  logic [2:0]             bit_cnt_q;
  logic [7:0]             shadow_q;
  logic                   armed_q, perr_q, ferr_q;
  logic                   len_q, two_stop_q;
  logic [1:0]             par_q;
  logic [7:0]             data_out_q;
  logic                   rx_done_q, rx_active_q, parity_err_q, frame_err_q;

  logic rs, sample, tick, start_det, last_bit, complete, par_en;

  assign rs     = sync_q[SYNC_STAGES-1];
  assign par_en = par_q[1] ^ par_q[0];

  // Input synchronizer; flops reset to the idle line level.
  always_ff @(posedge baud_clk) begin
    if (!arst_n) sync_q <= '1;
    else         sync_q <= {sync_q[SYNC_STAGES-2:0], rx};
  end

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;
  // Two-deep history of rs feeding the 2-of-3 vote.
  always_ff @(posedge baud_clk) begin
    if (!arst_n) hist_q <= 2'b11;
    else         hist_q <= {hist_q[0], rs};
  end
  assign sample = (rs & hist_q[0]) | (rs & hist_q[1]) | (hist_q[0] & hist_q[1]);
`else
  assign sample = rs;
`endif

  // State register.
  always_ff @(posedge baud_clk) begin
    if (!arst_n) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic: each non-idle state advances only on its sample tick.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:   if (start_det) state_d = S_START;
      S_START:  if (tick) state_d = sample ? S_IDLE : S_DATA;
      S_DATA:   if (tick && last_bit) state_d = par_en ? S_PARITY : S_STOP1;
      S_PARITY: if (tick) state_d = S_STOP1;
      S_STOP1:  if (tick) state_d = two_stop_q ? S_STOP2 : S_IDLE;
      S_STOP2:  if (tick) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from state and counters.
  always_comb begin
    tick = 1'b0;
    case (state_q)
      S_START:                             tick = (cnt_q == START_PT);
      S_DATA, S_PARITY, S_STOP1, S_STOP2:  tick = (cnt_q == LAST_PT);
      default:                             tick = 1'b0;
    endcase
    start_det = (state_q == S_IDLE) && armed_q && !rs;
    last_bit  = (bit_cnt_q == (len_q ? 3'd7 : 3'd6));
    complete  = tick && (((state_q == S_STOP1) && !two_stop_q) || (state_q == S_STOP2));
  end

  // Datapath: counters, shadow byte, error accumulation and held outputs.
  always_ff @(posedge baud_clk) begin
    if (!arst_n) begin
      cnt_q        <= '0;
      bit_cnt_q    <= '0;
      shadow_q     <= '0;
      armed_q      <= 1'b0;
      perr_q       <= 1'b0;
      ferr_q       <= 1'b0;
      len_q        <= 1'b0;
      two_stop_q   <= 1'b0;
      par_q        <= 2'b00;
      data_out_q   <= '0;
      rx_done_q    <= 1'b0;
      rx_active_q  <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
    end else begin
      rx_done_q <= 1'b0;
      if (start_det) begin
        // Frame format is frozen here so mid-frame config writes cannot corrupt it.
        cnt_q      <= '0;
        bit_cnt_q  <= '0;
        shadow_q   <= '0;
        armed_q    <= 1'b0;
        perr_q     <= 1'b0;
        ferr_q     <= 1'b0;
        len_q      <= data_length;
        two_stop_q <= stop_bits;
        par_q      <= parity_type;
      end else if (state_q == S_IDLE) begin
        // A break must return high before another start is accepted.
        if (rs) armed_q <= 1'b1;
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          case (state_q)
            S_START:  if (!sample) rx_active_q <= 1'b1;
            S_DATA: begin
              shadow_q[bit_cnt_q] <= sample;
              bit_cnt_q           <= bit_cnt_q + 3'd1;
            end
            S_PARITY: if (sample != ((^shadow_q) ^ par_q[0])) perr_q <= 1'b1;
            S_STOP1, S_STOP2: if (!sample) ferr_q <= 1'b1;
            default: ;
          endcase
        end
        if (complete) begin
          data_out_q   <= shadow_q;
          parity_err_q <= perr_q;
          frame_err_q  <= ferr_q | ~sample;
          rx_done_q    <= 1'b1;
          rx_active_q  <= 1'b0;
          // A high final stop sample counts as the line having returned idle.
          armed_q      <= sample;
        end
      end
    end
  end

  assign data_out   = data_out_q;
  assign rx_done    = rx_done_q;
  assign rx_active  = rx_active_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;

endmodule

// File: doc/uart_rx_sipo.md
Name: uart_rx_sipo

Overview:
UART receive deserializer (serial-in, parallel-out) on the far end of the link driven by the transmit PISO.
- Oversamples the serial line, detects the start bit, and shifts in 7 or 8 data bits LSB first.
- Checks the optional parity bit and 1 or 2 stop bits.
- Presents the received byte with a one-cycle done pulse and error flags.
- Frame configuration inputs match the transmitter's, so one register set drives both ends.

Parameters:
OVERSAMPLE, 16, baud_clk cycles per bit period; must be even and >= 4.
SYNC_STAGES, 2, flops in the rx input synchronizer; must be >= 2.

Ports:
baud_clk  input  1  clock; runs at OVERSAMPLE x baud rate
arst_n  input  1  reset; synchronous, active-low
rx  input  1  serial line; idle high
data_length  input  1  1 = 8 data bits, 0 = 7 data bits
stop_bits  input  1  1 = two stop bits, 0 = one stop bit
parity_type  input  2  01 = odd, 10 = even, 00 or 11 = no parity bit
data_out  output  8  received byte; bit 7 = 0 in 7-bit mode
rx_done  output  1  one-cycle pulse when a frame completes
rx_active  output  1  high from start-bit confirmation until rx_done
parity_err  output  1  parity mismatch on the last frame
frame_err  output  1  a stop bit was sampled low on the last frame

Behaviour:
- Reset: arst_n is sampled low on a baud_clk rising edge (synchronous). It forces:
  - state to IDLE; the sample counter and bit counter to 0;
  - synchronizer flops to 1;
  - data_out = 0, rx_done = 0, rx_active = 0, parity_err = 0, frame_err = 0.
  - Reset mid-frame abandons the frame; no rx_done is produced.
- Input path: rx passes through SYNC_STAGES flops. All logic uses the synchronized value rs.
- Configuration: data_length, stop_bits and parity_type are latched on the start-bit falling edge. Changes mid-frame have no effect on the current frame.
- State machine: IDLE, START, DATA, PARITY, STOP1, STOP2.
  - IDLE: armed only after rs has been seen high for at least one cycle since the last frame or reset, so a break cannot retrigger. While armed, rs = 0 -> START, sample counter cleared.
  - START: at counter = OVERSAMPLE/2-1, rs = 0 confirms the start bit -> DATA; counter cleared; rx_active set. rs = 1 at that point is a glitch -> IDLE; no flags change.
  - DATA: a sample is taken each time the counter reaches OVERSAMPLE-1; the counter then wraps to 0, which places every sample mid-bit. Bits shift into a shadow register LSB first. After 8 samples (data_length = 1) or 7 samples (data_length = 0), go to PARITY if parity_type is 01 or 10, else STOP1.
  - PARITY: one sample, compared against the shadow byte:
    - even parity expects the XOR of the data bits;
    - odd parity expects its inverse;
    - a mismatch sets the internal parity error. -> STOP1.
  - STOP1: one sample; 0 sets the internal frame error. -> STOP2 if stop_bits, else complete.
  - STOP2: one sample; 0 sets the internal frame error. -> complete.
- Completion, on the cycle after the final stop sample:
  - data_out, parity_err and frame_err load from the shadow register and internal flags;
  - rx_done = 1 for exactly one cycle; rx_active = 0; state returns to IDLE.
- Outputs hold their values until the next completion; the error flags are not sticky across frames.
- Latency: rx_done rises (OVERSAMPLE/2) + N*OVERSAMPLE + 1 cycles after the start falling edge is seen on rs. N = data bits + parity bits + stop bits.
- A falling edge arriving during the last stop half-bit is caught in IDLE. This allows back-to-back frames with no idle gap.

Optional Feature:
UART_RX_MAJORITY_EN
- Defined: each bit sample is the 2-of-3 majority of rs at counter = M-1, M and M+1, where M is the nominal sample point. The decision is made at M+1. The start confirmation uses the same vote. Sample timing and rx_done latency shift by +1 cycle.
- Undefined: a single sample at M.

Test Plan:
- 8N1 (data_length=1, stop_bits=0, parity_type=00), frame 0x75 -> rx_done pulses once; data_out=0x75; both errors 0; rx_done arrives 8+9*16+1=153 cycles after the edge on rs (OVERSAMPLE=16).
- 7E2 (data_length=0, stop_bits=1, parity_type=10), byte 0x35 with parity bit 0 -> data_out=0x35, parity_err=0. Repeating with parity bit 1 -> parity_err=1 and data_out still 0x35.
- 8O1, 0xA5 with correct odd parity bit 1, stop bit driven 0 -> frame_err=1, parity_err=0. Holding rx low afterwards produces no further rx_done until rx returns high and a new start arrives.
- rx low pulse of 4 cycles in IDLE -> returns to IDLE; rx_active stays 0; no rx_done; outputs unchanged from the previous frame.
- arst_n low for 1 cycle midway through DATA of 0xFF -> all outputs 0 and no rx_done. A following clean frame 0x3C is received correctly.
- Two back-to-back 8N1 frames 0x01 then 0x80 with no idle gap -> two rx_done pulses; data_out=0x01 then 0x80.
